// File: rtl/parallel_to_serial_shifter.sv
// parallel_to_serial_shifter
//   Parallel-in, serial-out shifter. Accepts a DEPTH-bit word over a
//   valid/ready handshake and emits it one bit per enabled clock on `out`.
//   Back-to-back words stream with no idle gap; `last` marks word ends.
//
//   Configuration macro: PARALLEL_TO_SERIAL_LSB_FIRST_EN
//     defined   -> LSB first (register shifts right, out = bit 0)
//     undefined -> MSB first (register shifts left,  out = bit DEPTH-1)
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   enable     in   1      shift advance qualifier while shifting
//   load_valid in   1      load_data holds a word to transmit
//   load_ready out  1      word can be accepted this cycle (combinational)
//   load_data  in   DEPTH  parallel word, sampled on the accept edge
//   out        out  1      serial data bit (registered)
//   out_valid  out  1      out carries a word bit (registered)
//   last       out  1      out is the final bit of the word (registered)

module parallel_to_serial_shifter #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [DEPTH-1:0] load_data,
  output logic             out,
  output logic             out_valid,
  output logic             last
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]   shifted_c;
  logic               accept_c;
  logic               out_d, out_valid_d, last_d;

  // Ready in IDLE, or on the final enabled bit so the next word follows with no gap.
  assign load_ready = (state_q == IDLE) | (enable & last);
  assign accept_c   = load_valid & load_ready;

  // One-position move toward the output end.
`ifdef PARALLEL_TO_SERIAL_LSB_FIRST_EN
  assign shifted_c = {1'b0, sreg_q[DEPTH-1:1]};
`else
  assign shifted_c = {sreg_q[DEPTH-2:0], 1'b0};
`endif

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      last      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      last      <= last_d;
    end
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    last_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SHIFT;
          sreg_d  = load_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (enable) begin
          if (cnt_q == CNT_LAST) begin
            if (accept_c) begin
              sreg_d = load_data;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
              sreg_d  = '0;
              cnt_d   = '0;
            end
          end else begin
            sreg_d = shifted_c;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next-state view so the first bit
    // appears right after the accept edge.
    out_valid_d = (state_d == SHIFT);
    last_d      = out_valid_d & (cnt_d == CNT_LAST);
`ifdef PARALLEL_TO_SERIAL_LSB_FIRST_EN
    out_d       = out_valid_d & sreg_d[0];
`else
    out_d       = out_valid_d & sreg_d[DEPTH-1];
`endif
  end

endmodule

// File: tb/tb_parallel_to_serial_shifter.sv
// Self-checking bench for parallel_to_serial_shifter (DEPTH = 8).
// Expected {bit, last} pairs are queued when a word is accepted and
// popped by a negedge monitor whenever a bit is consumed.

module tb_parallel_to_serial_shifter;

  localparam int unsigned DEPTH = 8;
`ifdef PARALLEL_TO_SERIAL_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [DEPTH-1:0] load_data = '0;
  logic             out;
  logic             out_valid;
  logic             last;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  logic [1:0] exp_q[$];

  parallel_to_serial_shifter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out        (out),
    .out_valid  (out_valid),
    .last       (last)
  );

  always #5 clk = ~clk;

  // Monitor: a bit is consumed on each edge where out_valid & enable.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        valid_cycles++;
        if (enable) begin
          logic [1:0] e;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_bit: out=%b last=%b with empty scoreboard", out, last);
          end else begin
            e = exp_q.pop_front();
            if ({out, last} !== e) begin
              errors++;
              $display("FAIL serial_bit: got out=%b last=%b expected out=%b last=%b at %0t",
                       out, last, e[1], e[0], $time);
            end
            checks++;
            if (load_ready !== e[0]) begin
              errors++;
              $display("FAIL ready_in_shift: got %b expected %b at %0t", load_ready, e[0], $time);
            end
          end
        end
      end else begin
        checks++;
        if (out !== 1'b0 || last !== 1'b0 || load_ready !== 1'b1) begin
          errors++;
          $display("FAIL idle_outputs: out=%b last=%b ready=%b expected 0 0 1 at %0t",
                   out, last, load_ready, $time);
        end
      end
    end
  end

  // Present a word, wait (bounded) for acceptance, queue its expected bits.
  task automatic send_word(input logic [DEPTH-1:0] d, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    load_data = d;
    load_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (load_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: word %h never accepted", d);
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        logic b;
        b = LSB_FIRST ? d[k] : d[DEPTH-1-k];
        exp_q.push_back({b, (k == int'(DEPTH) - 1)});
      end
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Wait (bounded) until the serial line goes idle, then realign to posedge+1.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: out_valid stuck high");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || last !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: out=%b valid=%b last=%b ready=%b expected 0 0 0 1",
               out, out_valid, last, load_ready);
    end
    #4;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    int w;
    enable = 1'b1;
    valid_cycles = 0;
    send_word(8'h0B, w);
    wait_idle();
    checks++;
    if (valid_cycles != 8) begin
      errors++;
      $display("FAIL single_valid_len: got %0d expected 8", valid_cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_leftover: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    enable = 1'b1;
    valid_cycles = 0;
    send_word(8'hFF, w);
    send_word(8'h00, w);
    checks++;
    if (w != 7) begin
      errors++;
      $display("FAIL b2b_ready_wait: got %0d expected 7", w);
    end
    wait_idle();
    checks++;
    if (valid_cycles != 16) begin
      errors++;
      $display("FAIL b2b_valid_len: got %0d expected 16", valid_cycles);
    end
  endtask

  task automatic test_stall();
    int w;
    enable = 1'b1;
    valid_cycles = 0;
    send_word(8'hA5, w);
    @(posedge clk);
    #1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: out=%b valid=%b expected 0 1 (stall %0d)", out, out_valid, i);
      end
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    wait_idle();
    checks++;
    if (valid_cycles != 11) begin
      errors++;
      $display("FAIL stall_valid_len: got %0d expected 11", valid_cycles);
    end
  endtask

  task automatic test_busy_rejection();
    int w;
    enable = 1'b1;
    valid_cycles = 0;
    send_word(8'h0B, w);
    repeat (4) @(posedge clk);
    #1;
    send_word(8'h3C, w);
    checks++;
    if (w != 3) begin
      errors++;
      $display("FAIL busy_reject_cycles: got %0d expected 3", w);
    end
    wait_idle();
    checks++;
    if (valid_cycles != 16) begin
      errors++;
      $display("FAIL busy_valid_len: got %0d expected 16", valid_cycles);
    end
  endtask

  task automatic test_reset_mid_word();
    int w;
    enable = 1'b1;
    send_word(8'h5A, w);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || last !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: out=%b valid=%b last=%b ready=%b expected 0 0 0 1",
               out, out_valid, last, load_ready);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    valid_cycles = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid_cycles != 0) begin
      errors++;
      $display("FAIL residual_bits: got %0d valid cycles expected 0", valid_cycles);
    end
    send_word(8'hC3, w);
    wait_idle();
    checks++;
    if (valid_cycles != 8) begin
      errors++;
      $display("FAIL post_reset_len: got %0d expected 8", valid_cycles);
    end
  endtask

  task automatic test_enable_idle();
    valid_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      enable = ~enable;
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    checks++;
    if (valid_cycles != 0 || out !== 1'b0) begin
      errors++;
      $display("FAIL enable_idle: valid_cycles=%0d out=%b expected 0 0", valid_cycles, out);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_busy_rejection();
    test_reset_mid_word();
    test_enable_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_leftover: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
